serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  single-cycle pulse marking valid result.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 carry  output  1  registered final carry-out.

Function
REQ-012 The block SHALL compute {carry,sum} = a + b + cin bit-serially, one bit per clock, through a single 1-bit full-adder cell.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding fixed in the shared package.
REQ-014 IDLE: on start=1 at an edge, latch a, b into shift registers, latch cin into the carry register, clear bit counter, go to RUN.
REQ-015 RUN: each edge, add LSBs of the operand shift registers with the carry register, shift the result bit into sum MSB-side, shift operands right, update carry register, increment counter.
REQ-016 RUN: on the edge processing bit WIDTH-1, go to DONE; carry output takes the final carry.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE; the next edge returns to IDLE.
REQ-018 Latency: start sampled at edge k -> done high during the cycle after edge k+WIDTH.
REQ-019 start while busy=1 (RUN or DONE) SHALL be ignored with no effect on operands or result.
REQ-020 sum and carry SHALL hold their last value from DONE until the next accepted start; they are not valid while busy in RUN.
REQ-021 Bit counter SHALL be ceil(log2(WIDTH)) bits wide and never wrap during an operation.

Reset
REQ-022 rst=1 SHALL force state IDLE, busy=0, done=0, sum=0, carry=0, counter=0, internal carry=0, on the next edge, overriding start.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no done pulse is produced for it.

Configuration
REQ-024 Macro SERIAL_ADD_OVF_EN defined: output ovf (1 bit) SHALL exist, equal to (carry into MSB) XOR (carry out of MSB), registered at the transition to DONE, reset 0, held like sum.
REQ-025 SERIAL_ADD_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the FSM state encoding constants and the default WIDTH constant.
REQ-027 The 1-bit adder SHALL be a sub-module instance of full_adder (ports a, b, cin, sum, carry); the controller contains only the sequencing, shift and carry registers.

Verification (WIDTH=8)
REQ-028 a=8'hFF, b=8'h01, cin=0, start 1 cycle -> done 8 edges later, sum=8'h00, carry=1.
REQ-029 a=8'h0F, b=8'h10, cin=1 -> sum=8'h20, carry=0; busy high from edge after start through DONE cycle.
REQ-030 start re-asserted with a=8'h55 during RUN of a=8'h01,b=8'h01 -> result sum=8'h02, exactly one done pulse.
REQ-031 rst asserted at RUN bit 3 -> next cycle IDLE, all outputs 0, no done; fresh start afterwards gives correct result.
REQ-032 Back-to-back: start held high continuously -> one operation per WIDTH+2 cycles, each done pulse one cycle wide.
REQ-033 With SERIAL_ADD_OVF_EN: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, carry=0, ovf=1; a=8'hFF, b=8'h01 -> ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
// Shared constants for the bit-serial adder: FSM state encoding and the
// default operand width. Imported by serial_adder_ctrl.
// ----------------------------------------------------------------------------
package serial_adder_pkg;

  // Default operand width; legal range is 2..32.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. The encoding is fixed here so every user of the
  // package agrees on it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// Single-bit combinational full adder; the only arithmetic cell used by the
// serial adder.
//   a, b   : operand bits
//   cin    : carry in
//   sum    : a ^ b ^ cin
//   carry  : carry out
// ----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign carry    = (a & b) | (cin & half_sum);

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
// Computes {carry, sum} = a + b + cin one bit per clock through a single
// full_adder instance. A start seen in IDLE captures the operands; WIDTH
// clocks later the result is presented with a one-cycle done pulse.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   start  : begin an addition (only honoured in IDLE)
//   a, b   : operands, captured on accepted start
//   cin    : carry in, captured on accepted start
//   busy   : high in RUN and DONE
//   done   : one-cycle pulse, result valid
//   sum    : registered result (held until the next accepted start)
//   carry  : registered final carry out
//   ovf    : signed overflow flag (only when SERIAL_ADD_OVF_EN is defined)
//
// Configuration
//   SERIAL_ADD_OVF_EN : when defined, adds the registered ovf output.
// ----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             carry
);

  // Counter indexes bits 0..WIDTH-1, so it never needs to hold WIDTH.
  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;      // running carry between bit positions
  logic             cout_q;       // final carry presented on the carry port
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  logic fa_sum;
  logic fa_carry;

  full_adder u_full_adder (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // NOTE: all state, including the operand/result shift registers, uses
  // non-blocking assignments and is cleared by the synchronous reset so an
  // aborted operation leaves no stale data visible on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Result bits enter at the MSB; after WIDTH shifts bit 0 lands
          // in the LSB position.
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
          carry_q <= fa_carry;
          if (cnt_q == LAST_BIT) begin
            cout_q  <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q is the carry into the MSB on this edge.
            ovf_q   <= carry_q ^ fa_carry;
`endif
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Directed self-checking bench for serial_adder_ctrl at WIDTH = 8.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, well away from the active edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .carry (carry)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one addition, wait (bounded) for done and check the result.
  task automatic do_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       input logic op_cin, input logic [W-1:0] exp_sum, input logic exp_carry);
    int n;
    a = op_a; b = op_b; cin = op_cin; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    n = 0;
    while (n < 20 && done !== 1'b1) begin
      step();
      n++;
      if (done !== 1'b1) check({tag, " busy in run"}, 32'(busy), 32'd1);
    end
    check({tag, " latency"}, 32'(n), 32'(W));
    check({tag, " busy in done"}, 32'(busy), 32'd1);
    check({tag, " sum"}, 32'(sum), 32'(exp_sum));
    check({tag, " carry"}, 32'(carry), 32'(exp_carry));
    step();
    check({tag, " done pulse width"}, 32'(done), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " sum held"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    int pulses;
    int wide;
    int first_at;
    int second_at;
    int third_at;
    logic prev_done;
    logic [W-1:0] got_sum;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset busy",  32'(busy),  32'd0);
    check("reset done",  32'(done),  32'd0);
    check("reset sum",   32'(sum),   32'd0);
    check("reset carry", 32'(carry), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("reset ovf",   32'(ovf),   32'd0);
`endif

    // Full carry ripple across all bits.
    do_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
    check("ff+01 ovf", 32'(ovf), 32'd0);
`endif
    // Carry-in used.
    do_op("0f+10+1", 8'h0F, 8'h10, 1'b1, 8'h20, 1'b0);
    do_op("a5+5a+1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    do_op("3c+42",   8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    do_op("7f+01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    check("7f+01 ovf", 32'(ovf), 32'd1);
`endif

    // start re-asserted while busy must be ignored.
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    got_sum = '0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) begin a = 8'h55; start = 1'b1; end
      if (c == 5) start = 1'b0;
      step();
      if (done === 1'b1) begin
        pulses++;
        got_sum = sum;
      end
    end
    check("ignore start pulses", 32'(pulses), 32'd1);
    check("ignore start sum", 32'(got_sum), 32'h02);

    // Reset in the middle of RUN, with start held high to test override.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    a = 8'hFF; start = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("abort busy",  32'(busy),  32'd0);
    check("abort done",  32'(done),  32'd0);
    check("abort sum",   32'(sum),   32'd0);
    check("abort carry", 32'(carry), 32'd0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    check("abort idle", 32'(busy), 32'd0);
    do_op("12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Back-to-back with start held high: one result every W+2 cycles.
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    pulses = 0; wide = 0; first_at = 0; second_at = 0; third_at = 0;
    prev_done = 1'b0;
    got_sum = 8'hAA;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (done === 1'b1) begin
        pulses++;
        if (prev_done === 1'b1) wide++;
        if (pulses == 1) begin first_at = c; got_sum = sum; end
        if (pulses == 2) second_at = c;
        if (pulses == 3) third_at = c;
      end
      prev_done = done;
    end
    start = 1'b0;
    check("b2b pulse count", 32'(pulses), 32'd4);
    check("b2b first done", 32'(first_at), 32'(W + 1));
    check("b2b period 1", 32'(second_at - first_at), 32'(W + 2));
    check("b2b period 2", 32'(third_at - second_at), 32'(W + 2));
    check("b2b wide pulses", 32'(wide), 32'd0);
    check("b2b sum", 32'(got_sum), 32'h00);
    step();
    step();
    check("b2b final idle", 32'(busy), 32'd0);
    check("b2b final carry", 32'(carry), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
